int_ctrl: RTL and testbench

- Interrupt controller directly downstream of top_timers.
- Consumes timer overflow flags (TF0/TF1), external pins INT0/INT1 and serial RI/TI.
- Applies IE enables and two-level IP priority with nesting, and presents one vectored request to the CPU through a req/ack handshake.
- Returns hardware-clear strobes for TF0/TF1 and owns the IE0/IE1 TCON flags.

---
 rtl/int_ctrl_pkg.sv | 45 ++++
 rtl/int_ctrl_ext_flag.sv | 44 ++++
 rtl/int_ctrl.sv | 155 +++++++++++++++
 tb/tb_int_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: source indices, IE/IP bit
// positions, FSM encoding and the default vector table.
package int_ctrl_pkg;

    localparam int unsigned NUM_SRC = 5;
    localparam int unsigned SRC_W   = 3;

    localparam logic [SRC_W-1:0] SRC_EXT0 = 3'd0;
    localparam logic [SRC_W-1:0] SRC_TF0  = 3'd1;
    localparam logic [SRC_W-1:0] SRC_EXT1 = 3'd2;
    localparam logic [SRC_W-1:0] SRC_TF1  = 3'd3;
    localparam logic [SRC_W-1:0] SRC_SER  = 3'd4;

    localparam int unsigned IE_EA  = 7;
    localparam int unsigned IE_ES  = 4;
    localparam int unsigned IE_ET1 = 3;
    localparam int unsigned IE_EX1 = 2;
    localparam int unsigned IE_ET0 = 1;
    localparam int unsigned IE_EX0 = 0;

    localparam int unsigned IP_PS  = 4;
    localparam int unsigned IP_PT1 = 3;
    localparam int unsigned IP_PX1 = 2;
    localparam int unsigned IP_PT0 = 1;
    localparam int unsigned IP_PX0 = 0;

    localparam logic [7:0] VEC_EXT0 = 8'h03;
    localparam logic [7:0] VEC_TF0  = 8'h0B;
    localparam logic [7:0] VEC_EXT1 = 8'h13;
    localparam logic [7:0] VEC_TF1  = 8'h1B;
    localparam logic [7:0] VEC_SER  = 8'h23;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // 8-bit wrap is intentional: the vector is only the low address byte.
    function automatic logic [7:0] calc_vector(input logic [7:0] base,
                                               input logic [7:0] stride,
                                               input logic [SRC_W-1:0] idx);
        return base + stride * {5'b0, idx};
    endfunction

endpackage

// File: rtl/int_ctrl_ext_flag.sv
// External interrupt pin front end: synchronizer, falling-edge detect and
// the IEx flag (edge mode latches, level mode follows the inverted pin).
module int_ctrl_ext_flag #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    input  logic it_i,
    input  logic clr_i,
    output logic flag_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   flag_q, flag_d;
    logic                   pin_s;
    logic                   fall;

    assign pin_s = sync_q[SYNC_STAGES-1];
    assign fall  = prev_q & ~pin_s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
        prev_d = pin_s;
        // A new edge outranks a clear arriving in the same cycle.
        flag_d = it_i ? (fall | (flag_q & ~clr_i)) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            flag_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            flag_q <= flag_d;
        end
    end

    assign flag_o = it_i ? flag_q : ~pin_s;

endmodule

// File: rtl/int_ctrl.sv
// Two-level vectored interrupt controller: masks, prioritises and nests five
// sources and hands one request at a time to the CPU over req/ack.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] VEC_BASE    = 8'h03,
    parameter logic [7:0] VEC_STRIDE  = 8'h08
) (
    input  logic       int_ctrl_machine_cycle_i,
    input  logic       int_ctrl_reset_i,
    input  logic       int_ctrl_int0_i,
    input  logic       int_ctrl_int1_i,
    input  logic       int_ctrl_sfr_tcon_it0_i,
    input  logic       int_ctrl_sfr_tcon_it1_i,
    input  logic       int_ctrl_sfr_tcon_tf0_i,
    input  logic       int_ctrl_sfr_tcon_tf1_i,
    input  logic       int_ctrl_sfr_scon_ri_i,
    input  logic       int_ctrl_sfr_scon_ti_i,
    input  logic [7:0] int_ctrl_sfr_ie_i,
    input  logic [7:0] int_ctrl_sfr_ip_i,
    input  logic       int_ctrl_ie0_clr_i,
    input  logic       int_ctrl_ie1_clr_i,
    input  logic       int_ctrl_hold_i,
    input  logic       int_ctrl_ack_i,
    input  logic       int_ctrl_reti_i,
    output logic       int_ctrl_req_o,
    output logic [7:0] int_ctrl_vector_o,
    output logic       int_ctrl_sfr_tcon_ie0_o,
    output logic       int_ctrl_sfr_tcon_ie1_o,
    output logic       int_ctrl_tf0_clr_o,
    output logic       int_ctrl_tf1_clr_o,
    output logic [1:0] int_ctrl_in_service_o
);

    logic                 clk, rst_n;
    state_e               state_q, state_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic [7:0]           vec_q, vec_d;
    logic                 lvl_q, lvl_d;
    logic [1:0]           isv_q, isv_d;
    logic                 tf0_clr_q, tf0_clr_d;
    logic                 tf1_clr_q, tf1_clr_d;
    logic                 ie0, ie1, ext0_clr, ext1_clr;
    logic [NUM_SRC-1:0]   flags, pending, hi_elig, lo_elig;
    logic                 win_vld, win_hi, launch, accept;
    logic [SRC_W-1:0]     win_idx;

    assign clk   = int_ctrl_machine_cycle_i;
    assign rst_n = int_ctrl_reset_i;

    assign accept   = (state_q == ST_REQ) && int_ctrl_ack_i;
    assign ext0_clr = int_ctrl_ie0_clr_i | (accept && src_q == SRC_EXT0);
    assign ext1_clr = int_ctrl_ie1_clr_i | (accept && src_q == SRC_EXT1);

    int_ctrl_ext_flag #(.SYNC_STAGES(SYNC_STAGES)) u_ext0 (
        .clk(clk), .rst_n(rst_n), .pin_i(int_ctrl_int0_i),
        .it_i(int_ctrl_sfr_tcon_it0_i), .clr_i(ext0_clr), .flag_o(ie0)
    );

    int_ctrl_ext_flag #(.SYNC_STAGES(SYNC_STAGES)) u_ext1 (
        .clk(clk), .rst_n(rst_n), .pin_i(int_ctrl_int1_i),
        .it_i(int_ctrl_sfr_tcon_it1_i), .clr_i(ext1_clr), .flag_o(ie1)
    );

    assign flags = {int_ctrl_sfr_scon_ri_i | int_ctrl_sfr_scon_ti_i,
                    int_ctrl_sfr_tcon_tf1_i, ie1, int_ctrl_sfr_tcon_tf0_i, ie0};
    assign pending = flags & int_ctrl_sfr_ie_i[IE_ES:IE_EX0]
                   & {NUM_SRC{int_ctrl_sfr_ie_i[IE_EA]}};
    assign hi_elig = pending & int_ctrl_sfr_ip_i[IP_PS:IP_PX0]
                   & {NUM_SRC{~isv_q[1]}};
    assign lo_elig = pending & ~int_ctrl_sfr_ip_i[IP_PS:IP_PX0]
                   & {NUM_SRC{isv_q == 2'b00}};

    // Descending scans so the lowest index wins; the high scan overrides the low one.
    always_comb begin
        win_vld = 1'b0;
        win_hi  = 1'b0;
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (lo_elig[i]) begin
                win_vld = 1'b1;
                win_idx = SRC_W'(i);
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (hi_elig[i]) begin
                win_vld = 1'b1;
                win_hi  = 1'b1;
                win_idx = SRC_W'(i);
            end
        end
    end

    assign launch = (state_q == ST_IDLE) && win_vld && !int_ctrl_hold_i;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_REQ;
            ST_REQ:  if (int_ctrl_ack_i || !pending[src_q]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        int_ctrl_req_o = (state_q == ST_REQ);
    end

    always_comb begin
        src_d = launch ? win_idx : src_q;
        lvl_d = launch ? win_hi : lvl_q;
        vec_d = launch ? calc_vector(VEC_BASE, VEC_STRIDE, win_idx) : vec_q;
        isv_d = isv_q;
        // RETI retires the innermost level before an ack in the same cycle lands.
        if (int_ctrl_reti_i) begin
            if (isv_q[1]) isv_d[1] = 1'b0;
            else          isv_d[0] = 1'b0;
        end
        if (accept) isv_d[lvl_q] = 1'b1;
        tf0_clr_d = accept && src_q == SRC_TF0;
        tf1_clr_d = accept && src_q == SRC_TF1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q     <= '0;
            lvl_q     <= 1'b0;
            vec_q     <= '0;
            isv_q     <= '0;
            tf0_clr_q <= 1'b0;
            tf1_clr_q <= 1'b0;
        end else begin
            src_q     <= src_d;
            lvl_q     <= lvl_d;
            vec_q     <= vec_d;
            isv_q     <= isv_d;
            tf0_clr_q <= tf0_clr_d;
            tf1_clr_q <= tf1_clr_d;
        end
    end

    assign int_ctrl_vector_o       = vec_q;
    assign int_ctrl_sfr_tcon_ie0_o = ie0;
    assign int_ctrl_sfr_tcon_ie1_o = ie1;
    assign int_ctrl_tf0_clr_o      = tf0_clr_q;
    assign int_ctrl_tf1_clr_o      = tf1_clr_q;
    assign int_ctrl_in_service_o   = isv_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: one task per scenario, inline comparisons.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, int0, int1, it0, it1, tf0, tf1, ri, ti;
    logic [7:0] ie, ip;
    logic       ie0_clr, ie1_clr, hold, ack, reti;
    logic       req, ie0_o, ie1_o, tf0_clr, tf1_clr;
    logic [7:0] vec;
    logic [1:0] isv;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    int_ctrl dut (
        .int_ctrl_machine_cycle_i(clk), .int_ctrl_reset_i(rst_n),
        .int_ctrl_int0_i(int0), .int_ctrl_int1_i(int1),
        .int_ctrl_sfr_tcon_it0_i(it0), .int_ctrl_sfr_tcon_it1_i(it1),
        .int_ctrl_sfr_tcon_tf0_i(tf0), .int_ctrl_sfr_tcon_tf1_i(tf1),
        .int_ctrl_sfr_scon_ri_i(ri), .int_ctrl_sfr_scon_ti_i(ti),
        .int_ctrl_sfr_ie_i(ie), .int_ctrl_sfr_ip_i(ip),
        .int_ctrl_ie0_clr_i(ie0_clr), .int_ctrl_ie1_clr_i(ie1_clr),
        .int_ctrl_hold_i(hold), .int_ctrl_ack_i(ack), .int_ctrl_reti_i(reti),
        .int_ctrl_req_o(req), .int_ctrl_vector_o(vec),
        .int_ctrl_sfr_tcon_ie0_o(ie0_o), .int_ctrl_sfr_tcon_ie1_o(ie1_o),
        .int_ctrl_tf0_clr_o(tf0_clr), .int_ctrl_tf1_clr_o(tf1_clr),
        .int_ctrl_in_service_o(isv)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req); end
        checks++; if (vec !== 8'h00) begin errors++; $display("FAIL rst_vec: got %h want 00", vec); end
        checks++; if ({ie0_o, ie1_o, tf0_clr, tf1_clr} !== 4'b0000) begin
            errors++; $display("FAIL rst_flags: got %b want 0000", {ie0_o, ie1_o, tf0_clr, tf1_clr}); end
        checks++; if (isv !== 2'b00) begin errors++; $display("FAIL rst_isv: got %b want 00", isv); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_tf0();
        ie = 8'h82; tf0 = 1'b1;
        step();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL tf0_req: got %b want 1", req); end
        checks++; if (vec !== 8'h0B) begin errors++; $display("FAIL tf0_vec: got %h want 0B", vec); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL tf0_req_drop: got %b want 0", req); end
        checks++; if (tf0_clr !== 1'b1) begin errors++; $display("FAIL tf0_clr: got %b want 1", tf0_clr); end
        checks++; if (isv !== 2'b01) begin errors++; $display("FAIL tf0_isv: got %b want 01", isv); end
        tf0 = 1'b0;
        step();
        checks++; if (tf0_clr !== 1'b0) begin errors++; $display("FAIL tf0_clr_pulse: got %b want 0", tf0_clr); end
        reti = 1'b1;
        step();
        reti = 1'b0;
        checks++; if (isv !== 2'b00) begin errors++; $display("FAIL tf0_reti: got %b want 00", isv); end
        ie = 8'h00;
    endtask

    task automatic test_ext0();
        it0 = 1'b1; ie = 8'h81; int0 = 1'b0;
        step();
        checks++; if (ie0_o !== 1'b0) begin errors++; $display("FAIL ext0_e1: got %b want 0", ie0_o); end
        step();
        checks++; if (ie0_o !== 1'b0) begin errors++; $display("FAIL ext0_e2: got %b want 0", ie0_o); end
        step();
        checks++; if (ie0_o !== 1'b1) begin errors++; $display("FAIL ext0_e3: got %b want 1", ie0_o); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL ext0_req_early: got %b want 0", req); end
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h03) begin
            errors++; $display("FAIL ext0_req: got req=%b vec=%h want 1/03", req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (ie0_o !== 1'b0 || req !== 1'b0 || isv !== 2'b01) begin
            errors++; $display("FAIL ext0_ack: got ie0=%b req=%b isv=%b want 0/0/01", ie0_o, req, isv); end
        step();
        checks++; if (ie0_o !== 1'b0) begin errors++; $display("FAIL ext0_no_reedge: got %b want 0", ie0_o); end
        reti = 1'b1;
        step();
        reti = 1'b0;
        it0 = 1'b0;
        step();
        checks++; if (ie0_o !== 1'b1 || req !== 1'b1 || vec !== 8'h03) begin
            errors++; $display("FAIL ext0_level_req: got ie0=%b req=%b vec=%h want 1/1/03", ie0_o, req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (ie0_o !== 1'b1 || isv !== 2'b01) begin
            errors++; $display("FAIL ext0_level_ack: got ie0=%b isv=%b want 1/01", ie0_o, isv); end
        int0 = 1'b1;
        step();
        step();
        checks++; if (ie0_o !== 1'b0) begin errors++; $display("FAIL ext0_level_release: got %b want 0", ie0_o); end
        reti = 1'b1;
        step();
        reti = 1'b0;
        ie = 8'h00;
    endtask

    task automatic test_priority();
        ie = 8'h8A; ip = 8'h08; tf0 = 1'b1; tf1 = 1'b1;
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h1B) begin
            errors++; $display("FAIL prio_first: got req=%b vec=%h want 1/1B", req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0; tf1 = 1'b0;
        checks++; if (tf1_clr !== 1'b1 || tf0_clr !== 1'b0 || isv !== 2'b10) begin
            errors++; $display("FAIL prio_ack: got tf1c=%b tf0c=%b isv=%b want 1/0/10", tf1_clr, tf0_clr, isv); end
        step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL prio_low_blocked: got %b want 0", req); end
        reti = 1'b1;
        step();
        reti = 1'b0;
        checks++; if (isv !== 2'b00 || req !== 1'b0) begin
            errors++; $display("FAIL prio_reti: got isv=%b req=%b want 00/0", isv, req); end
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h0B) begin
            errors++; $display("FAIL prio_second: got req=%b vec=%h want 1/0B", req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0; tf0 = 1'b0; reti = 1'b1;
        checks++; if (tf0_clr !== 1'b1 || isv !== 2'b01) begin
            errors++; $display("FAIL prio_ack2: got tf0c=%b isv=%b want 1/01", tf0_clr, isv); end
        step();
        reti = 1'b0;
        ie = 8'h00; ip = 8'h00;
    endtask

    task automatic test_nesting();
        ie = 8'h8B; ip = 8'h08; it0 = 1'b1; tf0 = 1'b1;
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h0B) begin
            errors++; $display("FAIL nest_low_req: got req=%b vec=%h want 1/0B", req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0; tf0 = 1'b0; tf1 = 1'b1;
        checks++; if (isv !== 2'b01) begin errors++; $display("FAIL nest_isv01: got %b want 01", isv); end
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h1B) begin
            errors++; $display("FAIL nest_high_req: got req=%b vec=%h want 1/1B", req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0; tf1 = 1'b0; int0 = 1'b0;
        checks++; if (isv !== 2'b11 || tf1_clr !== 1'b1) begin
            errors++; $display("FAIL nest_isv11: got isv=%b tf1c=%b want 11/1", isv, tf1_clr); end
        step();
        step();
        step();
        checks++; if (ie0_o !== 1'b1) begin errors++; $display("FAIL nest_ie0: got %b want 1", ie0_o); end
        step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL nest_blocked: got %b want 0", req); end
        reti = 1'b1;
        step();
        reti = 1'b0;
        checks++; if (isv !== 2'b01) begin errors++; $display("FAIL nest_reti1: got %b want 01", isv); end
        step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL nest_still_blocked: got %b want 0", req); end
        reti = 1'b1;
        step();
        reti = 1'b0;
        checks++; if (isv !== 2'b00 || req !== 1'b0) begin
            errors++; $display("FAIL nest_reti2: got isv=%b req=%b want 00/0", isv, req); end
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h03) begin
            errors++; $display("FAIL nest_ext0_req: got req=%b vec=%h want 1/03", req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0; int0 = 1'b1; reti = 1'b1;
        checks++; if (ie0_o !== 1'b0 || isv !== 2'b01) begin
            errors++; $display("FAIL nest_ext0_ack: got ie0=%b isv=%b want 0/01", ie0_o, isv); end
        step();
        reti = 1'b0; ie = 8'h00; ip = 8'h00;
        step();
        step();
        it0 = 1'b0;
    endtask

    task automatic test_withdraw_mask_hold();
        ie = 8'h82; tf0 = 1'b1;
        step();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL wd_req: got %b want 1", req); end
        tf0 = 1'b0;
        step();
        checks++; if (req !== 1'b0 || tf0_clr !== 1'b0) begin
            errors++; $display("FAIL wd_drop: got req=%b tf0c=%b want 0/0", req, tf0_clr); end
        step();
        checks++; if (tf0_clr !== 1'b0 || isv !== 2'b00) begin
            errors++; $display("FAIL wd_nostrobe: got tf0c=%b isv=%b want 0/00", tf0_clr, isv); end
        ie = 8'h02; tf0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (req !== 1'b0) begin errors++; $display("FAIL mask_ea cyc%0d: got %b want 0", i, req); end
        end
        ie = 8'h82; hold = 1'b1;
        step();
        step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL hold_block: got %b want 0", req); end
        hold = 1'b0;
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h0B) begin
            errors++; $display("FAIL hold_release: got req=%b vec=%h want 1/0B", req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0; tf0 = 1'b0; reti = 1'b1;
        step();
        reti = 1'b0; ie = 8'h00;
    endtask

    task automatic test_serial();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (req !== 1'b0 || isv !== 2'b00) begin
            errors++; $display("FAIL idle_ack: got req=%b isv=%b want 0/00", req, isv); end
        ie = 8'h90; ri = 1'b1;
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h23) begin
            errors++; $display("FAIL ser_req: got req=%b vec=%h want 1/23", req, vec); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (req !== 1'b0 || {tf0_clr, tf1_clr} !== 2'b00 || isv !== 2'b01) begin
            errors++; $display("FAIL ser_ack: got req=%b clr=%b isv=%b want 0/00/01", req, {tf0_clr, tf1_clr}, isv); end
        reti = 1'b1;
        step();
        reti = 1'b0;
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h23) begin
            errors++; $display("FAIL ser_rereq: got req=%b vec=%h want 1/23", req, vec); end
        ri = 1'b0;
        step();
        checks++; if (req !== 1'b0 || isv !== 2'b00) begin
            errors++; $display("FAIL ser_sw_clear: got req=%b isv=%b want 0/00", req, isv); end
        ie = 8'h00;
    endtask

    task automatic test_reset_mid_req();
        ie = 8'h84; it1 = 1'b0; int1 = 1'b0;
        step();
        step();
        checks++; if (ie1_o !== 1'b1) begin errors++; $display("FAIL rmid_ie1: got %b want 1", ie1_o); end
        step();
        checks++; if (req !== 1'b1 || vec !== 8'h13) begin
            errors++; $display("FAIL rmid_req: got req=%b vec=%h want 1/13", req, vec); end
        rst_n = 1'b0;
        step();
        checks++; if ({req, ie0_o, ie1_o, tf0_clr, tf1_clr} !== 5'b00000 || vec !== 8'h00 || isv !== 2'b00) begin
            errors++; $display("FAIL rmid_reset: got outs=%b vec=%h isv=%b want 00000/00/00",
                               {req, ie0_o, ie1_o, tf0_clr, tf1_clr}, vec, isv); end
        rst_n = 1'b1; int1 = 1'b1; ie = 8'h00;
        step();
    endtask

    initial begin
        rst_n = 1'b0; int0 = 1'b1; int1 = 1'b1; it0 = 1'b0; it1 = 1'b0;
        tf0 = 1'b0; tf1 = 1'b0; ri = 1'b0; ti = 1'b0; ie = 8'h00; ip = 8'h00;
        ie0_clr = 1'b0; ie1_clr = 1'b0; hold = 1'b0; ack = 1'b0; reti = 1'b0;
        test_reset();
        test_tf0();
        test_ext0();
        test_priority();
        test_nesting();
        test_withdraw_mask_hold();
        test_serial();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
